// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial computation of a - b - Bin, one bit per clock,
// LSB first, using only a 1-bit full-subtractor slice.
// Build option: define SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Bin,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             busy,
    output logic             done
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;

    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] res_nxt_s;
    logic             br_r;
    logic [CNT_W-1:0] cnt_r;

    logic             diff_bit_s;
    logic             br_nxt_s;
    logic             accept_s;
    logic             last_bit_s;
    logic             busy_nxt_s;
    logic             done_nxt_s;

    logic [WIDTH-1:0] diff_r;
    logic             bout_r;
    logic             busy_r;
    logic             done_r;

    // One-bit subtractor slice on the current LSBs plus the shifted result word
    always_comb begin
        diff_bit_s = a_sh_r[0] ^ b_sh_r[0] ^ br_r;
        br_nxt_s   = (~a_sh_r[0] & b_sh_r[0]) | (~(a_sh_r[0] ^ b_sh_r[0]) & br_r);
        res_nxt_s  = WIDTH'({diff_bit_s, res_r} >> 1'b1);
        accept_s   = (state_r == ST_IDLE) && start;
        last_bit_s = (state_r == ST_RUN) && (cnt_r == LAST_CNT);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: IDLE -> RUN on start, RUN for WIDTH bits, DONE for one cycle
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == LAST_CNT) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so busy/done come straight out of flops
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
            ST_RUN: begin
                busy_nxt_s = 1'b1;
                done_nxt_s = 1'b0;
            end
            ST_DONE: begin
                busy_nxt_s = 1'b1;
                done_nxt_s = 1'b1;
            end
            default: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Operand capture on accept, then one right shift per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r <= '0;
            b_sh_r <= '0;
            res_r  <= '0;
            br_r   <= 1'b0;
            cnt_r  <= '0;
        end else if (accept_s) begin
            a_sh_r <= a;
            b_sh_r <= b;
            res_r  <= '0;
            br_r   <= Bin;
            cnt_r  <= '0;
        end else if (state_r == ST_RUN) begin
            a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
            b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
            res_r  <= res_nxt_s;
            br_r   <= br_nxt_s;
            cnt_r  <= cnt_r + CNT_ONE;
        end
    end

    // Result outputs load only on the final bit, so partial results never show
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_r <= '0;
            bout_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
            if (last_bit_s) begin
                diff_r <= res_nxt_s;
                bout_r <= br_nxt_s;
            end
        end
    end

    assign Diff = diff_r;
    assign Bout = bout_r;
    assign busy = busy_r;
    assign done = done_r;

`ifdef SUB_OVF_EN
    logic a_msb_r;
    logic b_msb_r;
    logic ovf_r;

    // Keep the operand sign bits (the shifters lose them) and flag signed overflow at the end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                a_msb_r <= a[WIDTH-1];
                b_msb_r <= b[WIDTH-1];
            end
            if (last_bit_s) begin
                ovf_r <= (a_msb_r ^ b_msb_r) & (a_msb_r ^ diff_bit_s);
            end
        end
    end

    assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and randomized checks of serial_subtractor
// (WIDTH=4) against an arithmetic reference model. Define SUB_OVF_EN to also
// check the ovf output.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         Bin;
    logic [W-1:0] Diff;
    logic         Bout;
    logic         busy;
    logic         done;
`ifdef SUB_OVF_EN
    logic         ovf;
    logic         last_ovf;
`endif

    int           n_assert;
    int           n_fail;
    logic [W-1:0] last_diff;
    logic         last_bout;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .Bin   (Bin),
        .Diff  (Diff),
        .Bout  (Bout),
        .busy  (busy),
        .done  (done)
`ifdef SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {Bout,Diff} is a - b - Bin reduced modulo 2^(W+1)
    function automatic logic [W:0] ref_sub(input int av, input int bv, input int binv);
        int r;
        r = av - bv - binv;
        return (W+1)'(r);
    endfunction

    // Reference: signed result out of the W-bit two's-complement range
    function automatic logic ref_ovf(input logic [W-1:0] av, input logic [W-1:0] bv, input logic binv);
        int r;
        r = int'($signed(av)) - int'($signed(bv)) - int'(binv);
        return (r < -(1 << (W-1))) || (r > ((1 << (W-1)) - 1));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] av,
                                input logic [W-1:0] bv, input logic binv);
        logic [W:0] e;
        e = ref_sub(int'(av), int'(bv), int'(binv));
        check({tag, "_diff"}, 32'(Diff), 32'(e[W-1:0]));
        check({tag, "_bout"}, 32'(Bout), 32'(e[W]));
        last_diff = e[W-1:0];
        last_bout = e[W];
`ifdef SUB_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(ref_ovf(av, bv, binv)));
        last_ovf = ref_ovf(av, bv, binv);
`endif
    endtask

    // Run one operation from IDLE; called and returning at posedge+1
    task automatic run_op(input string tag, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic binv);
        int n;
        a = av; b = bv; Bin = binv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); Bin = 1'($urandom);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            check({tag, "_busy_run"}, 32'(busy), 32'd1);
            check({tag, "_hold_diff"}, 32'(Diff), 32'(last_diff));
            check({tag, "_hold_bout"}, 32'(Bout), 32'(last_bout));
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(W));
        check({tag, "_busy_done"}, 32'(busy), 32'd1);
        check_result(tag, av, bv, binv);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        check({tag, "_post_diff"}, 32'(Diff), 32'(last_diff));
    endtask

    logic [W-1:0] sa [0:17];
    logic [W-1:0] sb [0:17];
    logic         sbin [0:17];

    initial begin
        int off;
        int idx;
        n_assert  = 0;
        n_fail    = 0;
        last_diff = '0;
        last_bout = 1'b0;
`ifdef SUB_OVF_EN
        last_ovf  = 1'b0;
`endif
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; Bin = 1'b0;

        // Reset state
        #1;
        check("rst_diff", 32'(Diff), 32'd0);
        check("rst_bout", 32'(Bout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
`ifdef SUB_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", 32'(busy), 32'd0);

        // Directed cases
        run_op("d0101_0011", 4'b0101, 4'b0011, 1'b0);
        run_op("d0011_0101", 4'b0011, 4'b0101, 1'b0);
        run_op("d0000_0000_b", 4'b0000, 4'b0000, 1'b1);
        run_op("d0111_1111", 4'b0111, 4'b1111, 1'b0);
        run_op("d0101_0011_o", 4'b0101, 4'b0011, 1'b0);
        run_op("d1000_0000_b", 4'b1000, 4'b0000, 1'b1);

        // start held high with operands changing every cycle
        start = 1'b1;
        for (int i = 0; i < 18; i++) begin
            sa[i] = W'($urandom); sb[i] = W'($urandom); sbin[i] = 1'($urandom);
            a = sa[i]; b = sb[i]; Bin = sbin[i];
            @(posedge clk); #1;
            check("cont_done", 32'(done), 32'((i % 6) == 4));
            check("cont_busy", 32'(busy), 32'((i % 6) != 5));
            if ((i % 6) == 4) begin
                check_result("cont", sa[i-4], sb[i-4], sbin[i-4]);
            end else begin
                check("cont_hold", 32'(Diff), 32'(last_diff));
            end
        end
        start = 1'b0;

        // Reset mid-RUN aborts without a done pulse
        a = 4'b1111; b = 4'b0001; Bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_diff", 32'(Diff), 32'd0);
        check("abort_bout", 32'(Bout), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
`ifdef SUB_OVF_EN
        check("abort_ovf", 32'(ovf), 32'd0);
        last_ovf = 1'b0;
`endif
        last_diff = '0;
        last_bout = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort_nodone", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_idle", 32'(busy), 32'd0);
        run_op("after_rst", 4'b1001, 4'b0100, 1'b0);

        // All 512 operand/borrow combinations in a random order
        off = int'($urandom_range(0, 511));
        for (int i = 0; i < 512; i++) begin
            idx = (i * 197 + off) % 512;
            run_op("exh", W'(idx >> 5), W'((idx >> 1) & 15), 1'(idx & 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
